// File: rtl/midi_pkg.sv
// Shared MIDI definitions: byte-class constants, parser states and the note event record.
package midi_pkg;

  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [7:0] SYSEX_START     = 8'hF0;
  localparam logic [7:0] SYSEX_END       = 8'hF7;
  localparam logic [7:0] RT_BASE         = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2,
    SKIP
  } parse_state_t;

  typedef struct packed {
    logic       on;
    logic [3:0] chan;
    logic [6:0] note;
    logic [6:0] vel;
  } note_evt_t;

  // Program change (Cn) and channel pressure (Dn) carry a single data byte.
  function automatic logic one_data_byte(input logic [7:0] status);
    return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
  endfunction

endpackage

// File: rtl/midi_evt_reg.sv
// Single-entry valid/ready holding register for note events; flags a dropped load.
module midi_evt_reg
  import midi_pkg::*;
(
  input  logic      CLK,
  input  logic      RESET,
  input  logic      load,
  input  note_evt_t load_evt,
  input  logic      ready,
  output logic      valid,
  output note_evt_t evt,
  output logic      overrun
);

  logic take;

  // A full register can still take a new event when it drains in the same cycle.
  assign take = load & (~valid | ready);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid   <= 1'b0;
      evt     <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & valid & ~ready;
      if (take) begin
        valid <= 1'b1;
        evt   <= load_evt;
      end else if (valid & ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/midi_msg_ctrl.sv
// MIDI byte-stream parser: tracks running status, assembles channel-voice messages,
// forwards Note On/Off events through a holding register and drives the held-note LED.
module midi_msg_ctrl
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'h0,
  parameter logic       OMNI    = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BYTE_VALID,
  input  logic [7:0] BYTE_DATA,
  input  logic       FRAME_ERR,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic       EVT_ON,
  output logic [3:0] EVT_CHAN,
  output logic [6:0] EVT_NOTE,
  output logic [6:0] EVT_VEL,
  output logic [7:0] LED,
  output logic       OVERRUN,
  output logic       BUSY
);

  parse_state_t state_q, state_d;
  logic [7:0]   status_q, status_d;
  logic [6:0]   d1_q, d1_d;
  logic [7:0]   led_q;
  logic         complete;
  logic         is_note;
  logic         chan_ok;
  logic         emit;
  note_evt_t    evt_new;
  note_evt_t    evt_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      status_q <= '0;
      d1_q     <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      d1_q     <= d1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    d1_d     = d1_q;
    complete = 1'b0;
    if (BYTE_VALID && FRAME_ERR) begin
      state_d  = IDLE;
      status_d = '0;
    end else if (BYTE_VALID && (BYTE_DATA < RT_BASE)) begin
      if (BYTE_DATA == SYSEX_START) begin
        state_d  = SKIP;
        status_d = '0;
      end else if (BYTE_DATA[7:4] == 4'hF) begin
        state_d  = IDLE;
        status_d = '0;
      end else if (BYTE_DATA[7]) begin
        state_d  = WAIT_D1;
        status_d = BYTE_DATA;
      end else begin
        case (state_q)
          WAIT_D1: begin
            if (one_data_byte(status_q)) begin
              complete = 1'b1;
            end else begin
              d1_d    = BYTE_DATA[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            complete = 1'b1;
            state_d  = WAIT_D1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Only note messages ever produce events, and they always complete in WAIT_D2.
  assign is_note      = (status_q[7:4] == STATUS_NOTE_OFF) || (status_q[7:4] == STATUS_NOTE_ON);
  assign chan_ok      = OMNI || (status_q[3:0] == CHANNEL);
  assign emit         = complete & is_note & chan_ok;
  assign evt_new.chan = status_q[3:0];
  assign evt_new.note = d1_q;
  assign evt_new.vel  = BYTE_DATA[6:0];
  assign evt_new.on   = (status_q[7:4] == STATUS_NOTE_ON) && (BYTE_DATA[6:0] != 7'h00);

  // LED tracks every emitted event, including ones the holding register drops.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      led_q <= 8'h00;
    end else if (emit) begin
      if (evt_new.on) begin
        led_q <= {1'b1, evt_new.note};
      end else if (led_q == {1'b1, evt_new.note}) begin
        led_q <= 8'h00;
      end
    end
  end

  midi_evt_reg u_evt_reg (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (emit),
    .load_evt (evt_new),
    .ready    (EVT_READY),
    .valid    (EVT_VALID),
    .evt      (evt_q),
    .overrun  (OVERRUN)
  );

  assign EVT_ON   = evt_q.on;
  assign EVT_CHAN = evt_q.chan;
  assign EVT_NOTE = evt_q.note;
  assign EVT_VEL  = evt_q.vel;
  assign LED      = led_q;
  assign BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_midi_msg_ctrl.sv
// Bench for midi_msg_ctrl: an omni instance and a channel-2 instance share one byte stream
// and are compared every cycle against a message-level reference model.
module tb_midi_msg_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BYTE_VALID = 1'b0;
  logic [7:0] BYTE_DATA = 8'h00;
  logic       FRAME_ERR = 1'b0;
  logic       EVT_READY = 1'b0;

  logic       ev_valid [2];
  logic       ev_on    [2];
  logic [3:0] ev_chan  [2];
  logic [6:0] ev_note  [2];
  logic [6:0] ev_vel   [2];
  logic [7:0] led      [2];
  logic       ovr      [2];
  logic       busy     [2];

  midi_msg_ctrl #(.CHANNEL(4'h0), .OMNI(1'b1)) u_omni (
    .CLK(CLK), .RESET(RESET), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
    .FRAME_ERR(FRAME_ERR), .EVT_VALID(ev_valid[0]), .EVT_READY(EVT_READY),
    .EVT_ON(ev_on[0]), .EVT_CHAN(ev_chan[0]), .EVT_NOTE(ev_note[0]), .EVT_VEL(ev_vel[0]),
    .LED(led[0]), .OVERRUN(ovr[0]), .BUSY(busy[0])
  );

  midi_msg_ctrl #(.CHANNEL(4'h2), .OMNI(1'b0)) u_ch2 (
    .CLK(CLK), .RESET(RESET), .BYTE_VALID(BYTE_VALID), .BYTE_DATA(BYTE_DATA),
    .FRAME_ERR(FRAME_ERR), .EVT_VALID(ev_valid[1]), .EVT_READY(EVT_READY),
    .EVT_ON(ev_on[1]), .EVT_CHAN(ev_chan[1]), .EVT_NOTE(ev_note[1]), .EVT_VEL(ev_vel[1]),
    .LED(led[1]), .OVERRUN(ovr[1]), .BUSY(busy[1])
  );

  always #5 CLK = ~CLK;

  // Reference model: running status (-1 = none), sysex flag, collected data bytes.
  int rs;
  bit skip;
  int dq[$];
  bit m_valid [2];
  bit m_on    [2];
  bit m_ovr   [2];
  int m_chan  [2];
  int m_note  [2];
  int m_vel   [2];
  int m_led   [2];

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] seq[$];

  task automatic cmp(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    rs = -1;
    skip = 0;
    dq.delete();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_on[k] = 0; m_ovr[k] = 0;
      m_chan[k] = 0; m_note[k] = 0; m_vel[k] = 0; m_led[k] = 0;
    end
  endtask

  task automatic model_step(input bit bv, input logic [7:0] b, input bit fe, input bit rdy);
    bit comp = 0;
    bit on = 0;
    int n = 0, v = 0, ch = 0, hi, need;
    bit em, is_note;
    if (bv) begin
      if (fe) begin
        rs = -1; skip = 0; dq.delete();
      end else if (b >= 8'hF8) begin
      end else if (b == 8'hF0) begin
        rs = -1; skip = 1; dq.delete();
      end else if (b >= 8'hF1) begin
        rs = -1; skip = 0; dq.delete();
      end else if (b >= 8'h80) begin
        rs = int'(b); skip = 0; dq.delete();
      end else if (rs >= 0) begin
        dq.push_back(int'(b));
        hi = rs / 16;
        need = (hi == 12 || hi == 13) ? 1 : 2;
        if (dq.size() == need) begin
          comp = 1;
          n = dq[0];
          v = dq[need-1];
          ch = rs % 16;
          on = (hi == 9) && (v != 0);
          dq.delete();
        end
      end
    end
    is_note = (rs / 16 == 8) || (rs / 16 == 9);
    for (int k = 0; k < 2; k++) begin
      em = comp && is_note && (k == 0 || ch == 2);
      m_ovr[k] = 0;
      if (em) begin
        if (!m_valid[k] || rdy) begin
          m_valid[k] = 1; m_on[k] = on; m_chan[k] = ch; m_note[k] = n; m_vel[k] = v;
        end else begin
          m_ovr[k] = 1;
        end
        if (on) m_led[k] = 128 + n;
        else if (m_led[k] == 128 + n) m_led[k] = 0;
      end else if (m_valid[k] && rdy) begin
        m_valid[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      cmp("evt_valid", k, ev_valid[k], m_valid[k]);
      if (m_valid[k]) begin
        cmp("evt_on", k, ev_on[k], m_on[k]);
        cmp("evt_chan", k, ev_chan[k], m_chan[k]);
        cmp("evt_note", k, ev_note[k], m_note[k]);
        cmp("evt_vel", k, ev_vel[k], m_vel[k]);
      end
      cmp("led", k, led[k], m_led[k]);
      cmp("overrun", k, ovr[k], m_ovr[k]);
      cmp("busy", k, busy[k], (rs >= 0 || skip) ? 1 : 0);
    end
  endtask

  task automatic tick(input bit bv, input logic [7:0] b, input bit fe, input bit rdy);
    BYTE_VALID = bv;
    BYTE_DATA  = b;
    FRAME_ERR  = fe;
    EVT_READY  = rdy;
    @(posedge CLK);
    model_step(bv, b, fe, rdy);
    #1;
    BYTE_VALID = 1'b0;
    FRAME_ERR  = 1'b0;
    check_all();
  endtask

  task automatic send_seq(input bit rdy);
    foreach (seq[i]) tick(1, seq[i], 0, rdy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all();
    RESET = 1'b1;
    tick(0, 8'h00, 0, 0);

    // Single Note On
    seq = '{8'h90, 8'h3C, 8'h64};
    send_seq(0);
    cmp("c1_note", 0, ev_note[0], 32'h3C);
    cmp("c1_led", 0, led[0], 32'hBC);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 1);

    // Running status; 40 is not the held note, then Note Off clears LED
    seq = '{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00};
    send_seq(1);
    cmp("c2_led_hold", 0, led[0], 32'hBC);
    seq = '{8'h80, 8'h3C, 8'h10};
    send_seq(1);
    cmp("c2_led_clr", 0, led[0], 32'h00);
    tick(0, 8'h00, 0, 1);

    // Real-time byte inside a message
    seq = '{8'h90, 8'h3C, 8'hF8, 8'h64};
    send_seq(0);
    cmp("c3_vel", 0, ev_vel[0], 32'h64);
    tick(0, 8'h00, 0, 1);

    // Overrun while consumer stalls
    seq = '{8'h91, 8'h30, 8'h40, 8'h91, 8'h31, 8'h40};
    send_seq(0);
    cmp("c4_ovr", 0, ovr[0], 32'h1);
    tick(0, 8'h00, 0, 0);
    cmp("c4_note", 0, ev_note[0], 32'h30);
    tick(0, 8'h00, 0, 1);
    tick(0, 8'h00, 0, 1);

    // Channel filter and SysEx
    seq = '{8'h91, 8'h3C, 8'h64, 8'h92, 8'h3C, 8'h64};
    send_seq(1);
    cmp("c5_chan", 1, ev_chan[1], 32'h2);
    seq = '{8'hF0, 8'h7E, 8'h3C, 8'h64, 8'hF7, 8'h3C, 8'h64};
    send_seq(1);
    tick(0, 8'h00, 0, 1);

    // Frame error mid-message
    seq = '{8'h90, 8'h3C};
    send_seq(1);
    tick(1, 8'h3D, 1, 1);
    tick(1, 8'h64, 0, 1);
    cmp("c6_busy", 0, busy[0], 32'h0);

    // Asynchronous reset while an event is pending
    seq = '{8'h92, 8'h45, 8'h50};
    send_seq(0);
    #3 RESET = 1'b0;
    #1;
    model_reset();
    check_all();
    cmp("c7_valid", 1, ev_valid[1], 32'h0);
    #1 RESET = 1'b1;

    // Random byte stream
    for (int i = 0; i < 800; i++) begin
      int r;
      logic [7:0] b;
      bit bv, fe, rdy;
      r = $urandom_range(0, 99);
      fe = 0;
      if (r < 50) begin
        b = 8'($urandom_range(0, 127));
        if ($urandom_range(0, 7) == 0) b = 8'h00;
      end else if (r < 68) begin
        b = {3'b100, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3))};
      end else if (r < 78) begin
        b = 8'($urandom_range(8'hA0, 8'hEF));
      end else if (r < 86) begin
        b = 8'($urandom_range(8'hF0, 8'hF7));
      end else if (r < 95) begin
        b = 8'($urandom_range(8'hF8, 8'hFF));
      end else begin
        b = 8'($urandom_range(0, 255));
        fe = 1;
      end
      bv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      tick(bv, b, fe & bv, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_msg_ctrl.md
# midi_msg_ctrl

Byte-level MIDI message controller sitting between the serial byte deserializer and the LED/note consumers. It sequences the received byte stream into channel-voice messages, tracking status, running status and data-byte count. It emits Note On/Note Off events on a valid/ready handshake and drives the LED display with the currently held note. All other messages are parsed and discarded so that framing stays correct.

## Interface
- CHANNEL, 4'h0, MIDI channel accepted when OMNI = 0
- OMNI, 1'b1, 1 = accept all channels, 0 = accept only CHANNEL
- CLK  in  1  system clock, all state on posedge
- RESET  in  1  asynchronous, active-low reset
- BYTE_VALID  in  1  one-cycle strobe: BYTE_DATA holds a completed byte
- BYTE_DATA  in  8  received byte
- FRAME_ERR  in  1  qualifies BYTE_VALID: the stop bit was bad
- EVT_VALID  out  1  note event available
- EVT_READY  in  1  consumer accepts the event when EVT_VALID & EVT_READY
- EVT_ON  out  1  1 = Note On, 0 = Note Off
- EVT_CHAN  out  4  channel of the event
- EVT_NOTE  out  7  note number
- EVT_VEL  out  7  velocity (release velocity for Note Off)
- LED  out  8  {1'b1, note} while a note is held, 8'h00 otherwise
- OVERRUN  out  1  one-cycle pulse: a completed event was dropped
- BUSY  out  1  1 while the parser is mid-message (state WAIT_D1 or WAIT_D2, or a data-skip count is pending)

## Operation
- Byte classes:
  - status = 8'h80–8'hEF
  - system common = 8'hF0–8'hF7
  - real-time = 8'hF8–8'hFF
  - data = bit 7 clear
- Real-time bytes are ignored completely: no change to state, running status or outputs.
- Parser states:
  - IDLE: no running status.
  - WAIT_D1: status held, expecting data byte 1.
  - WAIT_D2: expecting data byte 2.
  - SKIP: discarding data bytes.
- Status byte from any state:
  - Latch the status as running status, then go to WAIT_D1.
  - Note Off (8n) and Note On (9n) set the "note" flag.
  - Other channel statuses clear the flag. The expected data count is 1 for Cn/Dn and 2 otherwise.
- F0 (SysEx start): clear running status, go to SKIP; stay there until F7 or any status byte. F1–F7 clear running status and go to IDLE; their data bytes are dropped in IDLE.
- Data byte:
  - IDLE: discarded.
  - WAIT_D1: latch as d1; go to WAIT_D2, or complete the message if the count is 1.
  - WAIT_D2: latch as d2 and complete the message. Return to WAIT_D1 (running status); the running status is kept.
- Completion: an event is generated only if the note flag is set and the channel matches (OMNI or chan == CHANNEL).
  - Note On with d2 = 0 is emitted as EVT_ON = 0.
- Event register (single entry):
  - Loaded on completion if it is empty, or if it is being accepted in the same cycle.
  - If it is full and not accepted, the new event is dropped, OVERRUN pulses, and the old event is kept.
- LED:
  - An emitted Note On loads the note into LED.
  - An emitted Note Off whose note equals the held note clears LED.
  - LED updates at the same edge the event register loads, even for a dropped event.
- FRAME_ERR with BYTE_VALID: discard the byte, clear running status, go to IDLE. A partially assembled message is lost; no event.

## Timing
- Reset values:
  - state IDLE, running status cleared
  - EVT_VALID = 0, EVT_ON/CHAN/NOTE/VEL = 0
  - LED = 8'h00, OVERRUN = 0, BUSY = 0
- EVT_VALID rises on the CLK edge after the BYTE_VALID cycle carrying the completing byte, i.e. one-cycle latency. Fields are stable while EVT_VALID = 1.
- EVT_VALID falls the edge after EVT_VALID & EVT_READY unless a new event loads in that same cycle, in which case it stays high with new fields.
- EVT_READY may be held high permanently. The block must not depend on EVT_READY being low before EVT_VALID.
- OVERRUN is high for exactly one cycle, in the cycle after the dropped completion.
- BYTE_VALID may arrive on consecutive cycles; every byte must be processed without stall.
- Reset asserted mid-message or mid-handshake clears everything immediately, including a pending event.

## Structure
- Shared package midi_pkg:
  - byte-class constants: STATUS_NOTE_OFF = 4'h8, STATUS_NOTE_ON = 4'h9, SYSEX_START = 8'hF0, SYSEX_END = 8'hF7, RT_BASE = 8'hF8
  - parser state enum: IDLE, WAIT_D1, WAIT_D2, SKIP
  - note event struct: on, chan, note, vel
- One natural sub-module: midi_evt_reg, the single-entry valid/ready holding register with overrun detect. The parser FSM stays in the top.

## Test plan
- 90 3C 64 → one event: ON = 1, CHAN = 0, NOTE = 3C, VEL = 64; LED = BC.
- 90 3C 64 40 00 (running status), EVT_READY = 1 → events (ON, 3C, 64) then (OFF, 40, 00). LED stays BC because 40 is not the held note. Then 80 3C 10 → LED = 00.
- 90 3C F8 64 (real-time in the middle) → identical event to case 1; F8 has no effect.
- EVT_READY = 0, send 91 30 40 then 91 31 40 → first event held, OVERRUN pulses once, EVT_NOTE stays 30. Raising EVT_READY then clears EVT_VALID.
- OMNI = 0, CHANNEL = 2: 91 3C 64 → no event; 92 3C 64 → event with CHAN = 2. F0 7E 3C 64 F7 → no event; 3C 64 afterwards → no event because running status is cleared.
- 90 3C then FRAME_ERR byte, then 64 → no event, state IDLE. Also, RESET pulsed while EVT_VALID = 1 → all outputs return to reset values asynchronously.
